// File: rtl/regfile_multiport.sv
// Multi-port register file: one write port, two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero r0 and a bulk-clear engine.
module regfile_multiport #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter int BYPASS   = 1,
   parameter int ZERO_R0  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_REGS-1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_ptr;
   logic [DATA_W-1:0] r_mem [NUM_REGS];
   logic              w_wr_ok;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < NUM_REGS_C);
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_R0 != 0) && (a == '0);
   endfunction

   // A write only lands (and only forwards) when the clear engine is idle.
   assign w_wr_ok = wr_en && (r_state == ST_IDLE) && in_range(wr_addr) && !is_zero_reg(wr_addr);

   always_comb begin
      rd_data_a = '0;
      if (in_range(rd_addr_a) && !is_zero_reg(rd_addr_a)) begin
         if ((BYPASS != 0) && w_wr_ok && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
         else                                                    rd_data_a = r_mem[rd_addr_a];
      end
   end

   always_comb begin
      rd_data_b = '0;
      if (in_range(rd_addr_b) && !is_zero_reg(rd_addr_b)) begin
         if ((BYPASS != 0) && w_wr_ok && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
         else                                                    rd_data_b = r_mem[rd_addr_b];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (clr_req) w_state_nxt = ST_CLEAR;
         ST_CLEAR: if (r_ptr == LAST_PTR) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Pointer saturates at the last register so it never indexes past the file.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= '0;
      end else if ((r_state == ST_IDLE) && clr_req) begin
         r_ptr <= '0;
      end else if ((r_state == ST_CLEAR) && (r_ptr != LAST_PTR)) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_mem[r_ptr] <= '0;
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign clr_busy  = (r_state == ST_CLEAR);
   assign clr_done  = (r_state == ST_DONE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default build, a no-bypass build and a
// zero-r0 / 12-entry build, all sharing the same input stimulus.
module tb_regfile_multiport;

   localparam int DW = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr_a;
   logic [AW-1:0] rd_addr_b;
   logic          clr_req;

   logic [DW-1:0] rd_a, rd_b, nb_rd_a, nb_rd_b, z_rd_a, z_rd_b;
   logic          busy, done, nb_busy, nb_done, z_busy, z_done;
   logic [1:0]    dbg, nb_dbg, z_dbg;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_multiport #(.DATA_W(DW), .NUM_REGS(16), .ADDR_W(AW), .BYPASS(1), .ZERO_R0(0)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b),
      .clr_req(clr_req), .clr_busy(busy), .clr_done(done), .dbg_state(dbg));

   regfile_multiport #(.DATA_W(DW), .NUM_REGS(16), .ADDR_W(AW), .BYPASS(0), .ZERO_R0(0)) dut_nb (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(nb_rd_a), .rd_addr_b(rd_addr_b), .rd_data_b(nb_rd_b),
      .clr_req(clr_req), .clr_busy(nb_busy), .clr_done(nb_done), .dbg_state(nb_dbg));

   regfile_multiport #(.DATA_W(DW), .NUM_REGS(12), .ADDR_W(AW), .BYPASS(1), .ZERO_R0(1)) dut_z (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_data_a(z_rd_a), .rd_addr_b(rd_addr_b), .rd_data_b(z_rd_b),
      .clr_req(clr_req), .clr_busy(z_busy), .clr_done(z_done), .dbg_state(z_dbg));

   // Drives one write across a full cycle; returns at a negedge with wr_en low.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = 4'd5; rd_addr_b = 4'd0; clr_req = 1'b0;
      #12;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (dbg !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg); end
      total++; if (rd_a !== 16'h0000) begin bad++; $display("FAIL reset_rd_a: got %h want 0000", rd_a); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic_rw();
      do_write(4'd5, 16'hBEEF);
      do_write(4'd10, 16'h1234);
      rd_addr_a = 4'd5; rd_addr_b = 4'd10;
      #1;
      total++; if (rd_a !== 16'hBEEF) begin bad++; $display("FAIL basic_rd_a: got %h want beef", rd_a); end
      total++; if (rd_b !== 16'h1234) begin bad++; $display("FAIL basic_rd_b: got %h want 1234", rd_b); end
      for (int i = 0; i < 16; i++) begin
         if (i == 5 || i == 10) continue;
         @(negedge clk);
         rd_addr_a = AW'(i); rd_addr_b = AW'(15 - i);
         #1;
         total++; if (rd_a !== 16'h0000) begin bad++; $display("FAIL basic_zero_a r%0d: got %h want 0000", i, rd_a); end
      end
   endtask

   task automatic test_bypass();
      do_write(4'd3, 16'h0001);
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hA5A5; rd_addr_a = 4'd3; rd_addr_b = 4'd3;
      #1;
      total++; if (rd_a !== 16'hA5A5) begin bad++; $display("FAIL bypass_a: got %h want a5a5", rd_a); end
      total++; if (rd_b !== 16'hA5A5) begin bad++; $display("FAIL bypass_b: got %h want a5a5", rd_b); end
      total++; if (nb_rd_a !== 16'h0001) begin bad++; $display("FAIL nobypass_a: got %h want 0001", nb_rd_a); end
      total++; if (nb_rd_b !== 16'h0001) begin bad++; $display("FAIL nobypass_b: got %h want 0001", nb_rd_b); end
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      total++; if (nb_rd_a !== 16'hA5A5) begin bad++; $display("FAIL nobypass_after_a: got %h want a5a5", nb_rd_a); end
      total++; if (nb_rd_b !== 16'hA5A5) begin bad++; $display("FAIL nobypass_after_b: got %h want a5a5", nb_rd_b); end
   endtask

   task automatic test_zero_r0();
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
      #1;
      total++; if (z_rd_a !== 16'h0000) begin bad++; $display("FAIL zero_r0_byp_a: got %h want 0000", z_rd_a); end
      total++; if (z_rd_b !== 16'h0000) begin bad++; $display("FAIL zero_r0_byp_b: got %h want 0000", z_rd_b); end
      total++; if (rd_a !== 16'hFFFF) begin bad++; $display("FAIL r0_normal_byp: got %h want ffff", rd_a); end
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 4'd13; wr_data = 16'h5555; rd_addr_a = 4'd0; rd_addr_b = 4'd13;
      #1;
      total++; if (z_rd_a !== 16'h0000) begin bad++; $display("FAIL zero_r0_stored: got %h want 0000", z_rd_a); end
      total++; if (z_rd_b !== 16'h0000) begin bad++; $display("FAIL oor_byp: got %h want 0000", z_rd_b); end
      total++; if (rd_b !== 16'h5555) begin bad++; $display("FAIL inrange_byp: got %h want 5555", rd_b); end
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      total++; if (z_rd_b !== 16'h0000) begin bad++; $display("FAIL oor_stored: got %h want 0000", z_rd_b); end
      total++; if (rd_a !== 16'hFFFF) begin bad++; $display("FAIL r0_normal_stored: got %h want ffff", rd_a); end
   endtask

   task automatic test_bulk_clear();
      logic [DW-1:0] exp_a, exp_b;
      for (int i = 0; i < 16; i++) do_write(AW'(i), DW'(32'h1111 * i));
      clr_req = 1'b1;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_not_yet_busy: got %b want 0", busy); end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         clr_req = 1'b0;
         wr_en = (k == 4); wr_addr = 4'd4; wr_data = 16'h0BAD;
         rd_addr_a = AW'(k);
         rd_addr_b = (k == 0 || k == 8) ? 4'd15 : AW'(k - 1);
         exp_a = DW'(32'h1111 * k);
         exp_b = (k == 0 || k == 8) ? 16'hFFFF : 16'h0000;
         #1;
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy k%0d: got %b want 1", k, busy); end
         total++; if (done !== 1'b0) begin bad++; $display("FAIL clr_early_done k%0d: got %b want 0", k, done); end
         total++; if (rd_a !== exp_a) begin bad++; $display("FAIL clr_pending k%0d: got %h want %h", k, rd_a, exp_a); end
         total++; if (rd_b !== exp_b) begin bad++; $display("FAIL clr_cleared k%0d: got %h want %h", k, rd_b, exp_b); end
      end
      @(negedge clk);
      wr_en = 1'b0; rd_addr_a = 4'd4; rd_addr_b = 4'd15;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %b want 0", busy); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL done_pulse: got %b want 1", done); end
      total++; if (dbg !== 2'd2) begin bad++; $display("FAIL done_state: got %0d want 2", dbg); end
      total++; if (rd_a !== 16'h0000) begin bad++; $display("FAIL dropped_write: got %h want 0000", rd_a); end
      total++; if (rd_b !== 16'h0000) begin bad++; $display("FAIL r15_cleared: got %h want 0000", rd_b); end
      @(negedge clk);
      #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width: got %b want 0", done); end
      total++; if (dbg !== 2'd0) begin bad++; $display("FAIL back_idle: got %0d want 0", dbg); end
   endtask

   task automatic test_clear_held();
      int busy_cnt;
      bit seen;
      @(negedge clk);
      clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h2222;
      @(negedge clk);
      wr_en = 1'b0; rd_addr_a = 4'd2;
      #1;
      total++; if (rd_a !== 16'h2222) begin bad++; $display("FAIL req_edge_write: got %h want 2222", rd_a); end
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         #1;
         if (busy !== 1'b1) break;
         busy_cnt++;
      end
      total++; if (busy_cnt != 16) begin bad++; $display("FAIL busy_len: got %0d want 16", busy_cnt); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL held_done: got %b want 1", done); end
      @(negedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_idle_gap: got %b want 0", busy); end
      total++; if (rd_a !== 16'h0000) begin bad++; $display("FAIL req_write_cleared: got %h want 0000", rd_a); end
      @(negedge clk);
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_restart: got %b want 1", busy); end
      clr_req = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         #1;
         if (done === 1'b1) begin seen = 1'b1; break; end
      end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL restart_done_timeout: got %b want 1", seen); end
      @(negedge clk);
   endtask

   task automatic test_async_reset_mid_clear();
      bit done_seen;
      do_write(4'd9, 16'h9999);
      do_write(4'd12, 16'hCCCC);
      clr_req = 1'b1;
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         clr_req = 1'b0;
      end
      rd_addr_a = 4'd9; rd_addr_b = 4'd12;
      #1;
      total++; if (rd_a !== 16'h9999) begin bad++; $display("FAIL midclr_pending: got %h want 9999", rd_a); end
      #1;
      reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
      total++; if (dbg !== 2'd0) begin bad++; $display("FAIL arst_state: got %0d want 0", dbg); end
      total++; if (rd_a !== 16'h0000) begin bad++; $display("FAIL arst_r9: got %h want 0000", rd_a); end
      total++; if (rd_b !== 16'h0000) begin bad++; $display("FAIL arst_r12: got %h want 0000", rd_b); end
      done_seen = (done === 1'b1);
      @(negedge clk);
      done_seen = done_seen | (done === 1'b1);
      reset = 1'b1;
      wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h6666;
      @(negedge clk);
      wr_en = 1'b0; rd_addr_a = 4'd6;
      #1;
      total++; if (rd_a !== 16'h6666) begin bad++; $display("FAIL post_rst_write: got %h want 6666", rd_a); end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         #1;
         done_seen = done_seen | (done === 1'b1) | (busy === 1'b1);
      end
      total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL arst_no_done: got %b want 0", done_seen); end
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_bypass();
      test_zero_r0();
      test_bulk_clear();
      test_clear_held();
      test_async_reset_mid_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
